// File: rtl/spi_quad_rx2iram.sv
// spi_quad_rx2iram: quad-SPI read data capture, nibble-to-word assembly and FIFO-buffered IRAM writer (optional checksum via SPI_RX_CHECKSUM_EN)
//   CLK/ARESETn : clock, synchronous active-high reset
//   start, base_addr, num_words : load request from the command FSM, honoured in IDLE
//   io_valid, io_in             : one nibble per cycle, {IO3..IO0}
//   rx_last                     : pulse when the final nibble is accepted
//   iram_we/ready/addr/wdata    : IRAM write port, data from FIFO head
//   busy, done, overflow        : status; overflow is sticky until start
//   checksum                    : XOR of popped words, present only with SPI_RX_CHECKSUM_EN
module spi_quad_rx2iram #(
  parameter int DATA_SIZE  = 32,
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 CLK,
  input  logic                 ARESETn,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [15:0]          num_words,
  input  logic                 io_valid,
  input  logic [3:0]           io_in,
  output logic                 rx_last,
  output logic                 iram_we,
  input  logic                 iram_ready,
  output logic [ADDR_W-1:0]    iram_addr,
  output logic [DATA_SIZE-1:0] iram_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
`ifdef SPI_RX_CHECKSUM_EN
  ,
  output logic [DATA_SIZE-1:0] checksum
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_base, r_pops;
  logic [15:0] r_num, r_wcnt;
  logic [2:0] r_nib;
  logic [DATA_SIZE-1:0] r_word, w_word;
  logic [DATA_SIZE-1:0] r_mem [FIFO_DEPTH];
  logic [PW:0] r_wp, r_rp;
  logic r_ovf;
  logic w_start, w_take, w_push, w_pop, w_full, w_empty, w_store;
`ifdef SPI_RX_CHECKSUM_EN
  logic [DATA_SIZE-1:0] r_csum;
  assign checksum = r_csum;
`endif
  assign w_start = r_state == IDLE && start;
  assign w_take = r_state == CAPTURE && io_valid;
  assign w_push = w_take && r_nib == 3'd7;
  assign w_empty = r_wp == r_rp;
  assign w_full = r_wp[PW] != r_rp[PW] && r_wp[PW-1:0] == r_rp[PW-1:0];
  assign w_pop = !w_empty && iram_ready;
  // a push into a full FIFO still lands if the head leaves in the same cycle
  assign w_store = w_push && (!w_full || w_pop);
  // even nibble -> high half of byte k/2, odd nibble -> low half
  assign w_word = r_word | (DATA_SIZE'(io_in) << {r_nib[2:1], ~r_nib[0], 2'b00});
  assign iram_we = !w_empty;
  assign iram_wdata = w_empty ? '0 : r_mem[r_rp[PW-1:0]];
  assign iram_addr = r_base + r_pops;
  assign overflow = r_ovf;
  always_comb begin
    w_next = r_state;
    rx_last = 1'b0;
    done = 1'b0;
    busy = r_state != IDLE;
    case (r_state)
      IDLE: if (start) w_next = num_words == 16'd0 ? DONE : CAPTURE;
      CAPTURE: if (w_push && r_wcnt + 16'd1 == r_num) begin
        rx_last = 1'b1;
        w_next = DRAIN;
      end
      DRAIN: if (w_empty) w_next = DONE;
      default: begin
        done = 1'b1;
        w_next = IDLE;
      end
    endcase
  end
  always_ff @(posedge CLK)
    r_state <= ARESETn ? IDLE : w_next;
  always_ff @(posedge CLK)
    if (w_store) r_mem[r_wp[PW-1:0]] <= w_word;
  always_ff @(posedge CLK) begin
    if (ARESETn) begin
      r_base <= '0;
      r_pops <= '0;
      r_num <= '0;
      r_wcnt <= '0;
      r_nib <= '0;
      r_word <= '0;
      r_wp <= '0;
      r_rp <= '0;
      r_ovf <= 1'b0;
`ifdef SPI_RX_CHECKSUM_EN
      r_csum <= '0;
`endif
    end else begin
      if (w_start) begin
        r_base <= base_addr;
        r_num <= num_words;
        r_wcnt <= '0;
        r_nib <= '0;
        r_word <= '0;
        r_pops <= '0;
        r_ovf <= 1'b0;
`ifdef SPI_RX_CHECKSUM_EN
        r_csum <= '0;
`endif
      end
      if (w_take) begin
        r_nib <= r_nib + 3'd1;
        r_word <= w_push ? '0 : w_word;
      end
      if (w_push) begin
        r_wcnt <= r_wcnt + 16'd1;
        if (!w_store) r_ovf <= 1'b1;
      end
      if (w_store) r_wp <= r_wp + (PW+1)'(1);
      if (w_pop) begin
        r_rp <= r_rp + (PW+1)'(1);
        r_pops <= r_pops + ADDR_W'(1);
`ifdef SPI_RX_CHECKSUM_EN
        r_csum <= r_csum ^ iram_wdata;
`endif
      end
    end
  end
endmodule
